serial_cfg_tx: RTL
==================

SERIAL_CFG_TX -- requirements
Module: serial_cfg_tx

Interface
REQ-001 Parameter GAP_CYCLES, default 2, legal range 1..7: number of idle i_sclk cycles with o_frame low between back-to-back frames.
REQ-002 i_sclk  input  1  serial bit clock; all state updates on its rising edge.
REQ-003 i_resetbAll  input  1  reset, asynchronous, active-low.
REQ-004 i_load  input  1  request to send one configuration frame.
REQ-005 i_gain  input  3  gain code, sampled when a load is accepted.
REQ-006 i_mode  input  2  mode/trim bits (frame bits d0, d1), sampled when a load is accepted.
REQ-007 i_abort  input  1  synchronous abort of the current and pending frames.
REQ-008 o_accept  output  1  one-cycle pulse: load captured into the holding buffer.
REQ-009 o_sdout  output  1  serial data; feeds the backend i_sdin.
REQ-010 o_frame  output  1  high exactly while frame bits d0..d4 are driven on o_sdout.
REQ-011 o_busy  output  1  high while a frame is shifting, in gap, or the buffer is full.
REQ-012 o_done  output  1  one-cycle pulse after the last bit of a frame.
REQ-013 o_frame_cnt  output  4  count of completed frames, wraps 15->0.

Function
REQ-014 Frame format: 5 bits, d0 first: d0=i_mode[0], d1=i_mode[1], d2=i_gain[2], d3=i_gain[1], d4=i_gain[0]; the receiver therefore reconstructs gain MSB-first from d2..d4.
REQ-015 All outputs are registered; each bit is held on o_sdout for exactly one i_sclk period, changing only on a rising edge.
REQ-016 Holding buffer: one 5-bit entry plus a full flag.
REQ-017 A load is accepted at an edge where i_load=1, i_abort=0, and the buffer is empty or being transferred to the shifter at that same edge.
REQ-018 On acceptance: capture {i_gain, i_mode}, set full, and drive o_accept=1 for that one cycle.
REQ-019 i_load with the buffer full and not draining is ignored with no o_accept; the requester holds i_load until o_accept.
REQ-020 States: IDLE, SHIFT, GAP.
REQ-021 IDLE: o_frame=0, o_sdout=0; if buffer full at an edge, move entry to the shift register, clear full, output d0, o_frame=1, bit index=0, go to SHIFT.
REQ-022 SHIFT: bit index<4 -> increment and output next bit.
REQ-023 SHIFT: bit index=4 -> o_frame=0, o_sdout=0, o_done=1 for one cycle, o_frame_cnt+1 (mod 16), load gap counter, go to GAP.
REQ-024 GAP: o_frame=0, o_sdout=0 for exactly GAP_CYCLES cycles counted from the o_done edge.
REQ-025 GAP exit: if buffer full, launch the next frame directly (d0 out, go to SHIFT); otherwise go to IDLE.
REQ-026 Latency from idle/empty, i_load sampled at edge N: o_accept high N..N+1; d0 and o_frame high after N+1; d4 after N+5; o_done after N+6.
REQ-027 Back-to-back frames: o_frame low exactly GAP_CYCLES cycles between frames, with no gap when the buffer is refilled during SHIFT.
REQ-028 o_busy = (state != IDLE) | buffer full, registered alongside state.
REQ-029 i_abort=1 at an edge has top priority: state IDLE, o_frame=0, o_sdout=0, buffer cleared, no o_done, no o_accept, o_frame_cnt unchanged.
REQ-030 An aborted partial frame is not counted; the receiver is re-synchronised only by i_resetbAll.

Reset
REQ-031 i_resetbAll low asynchronously forces: state IDLE, buffer empty, bit index 0, gap counter 0, o_sdout=0, o_frame=0, o_busy=0, o_done=0, o_accept=0, o_frame_cnt=0.
REQ-032 Reset asserted mid-frame truncates the frame immediately; after release, the first accepted load behaves as REQ-026.

Verification
REQ-033 Single frame: i_gain=3'b101, i_mode=2'b10, pulse i_load -> o_sdout sequence 0,1,1,0,1 with o_frame high 5 cycles, o_done one cycle later, o_frame_cnt=1.
REQ-034 Loopback: drive backend i_sdin/i_sclk from this block with gain=3'b110 -> backend o_gain=3'b110 after its WAIT_SERIAL state.
REQ-035 Back-to-back: hold i_load with gains 3'b001 then 3'b111 -> second o_accept during first SHIFT, o_frame low exactly 2 cycles between frames, o_frame_cnt=2.
REQ-036 Buffer full: third i_load while shifting with buffer full -> no o_accept until the buffer drains, then accepted; no frame lost or duplicated.
REQ-037 Abort after bit d2 -> o_frame=0 and o_sdout=0 next cycle, no o_done, o_frame_cnt unchanged, buffer empty, o_busy=0.
REQ-038 Counter wrap and reset: 16 frames -> o_frame_cnt=0; i_resetbAll low mid-frame -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/serial_cfg_tx.sv
// serial_cfg_tx: serialises a 5-bit configuration word {gain, mode} onto a
// single data line, d0 first, framed by o_frame. A one-entry holding buffer
// lets the next word be queued while the current one shifts out, so frames
// can run back to back separated only by the GAP_CYCLES idle gap.
module serial_cfg_tx #(
    parameter int unsigned GAP_CYCLES = 2   // legal range 1..7
) (
    input  logic       i_sclk,
    input  logic       i_resetbAll,
    input  logic       i_load,
    input  logic [2:0] i_gain,
    input  logic [1:0] i_mode,
    input  logic       i_abort,
    output logic       o_accept,
    output logic       o_sdout,
    output logic       o_frame,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // The gap counter is loaded on the o_done edge and the frame relaunches
    // when it reaches zero, giving exactly GAP_CYCLES low cycles of o_frame.
    localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);

    state_t     state_q,   state_d;
    logic [4:0] buf_q,     buf_d;       // bit i holds frame bit d_i
    logic       full_q,    full_d;
    logic [3:0] shreg_q,   shreg_d;     // remaining bits d1..d4, LSB next out
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [2:0] gap_cnt_q, gap_cnt_d;
    logic       sdout_q,   sdout_d;
    logic       frame_q,   frame_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;
    logic       accept_q,  accept_d;
    logic [3:0] cnt_q,     cnt_d;
    logic       launch;

    // Next-state logic: abort dominates, then frame sequencing, then buffer fill.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        full_d    = full_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        sdout_d   = 1'b0;
        frame_d   = 1'b0;
        done_d    = 1'b0;
        accept_d  = 1'b0;
        cnt_d     = cnt_q;
        launch    = 1'b0;

        if (i_abort) begin
            // Drop both the frame in flight and the queued word.
            state_d   = ST_IDLE;
            full_d    = 1'b0;
            bit_idx_d = 3'd0;
            gap_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (full_q) begin
                        launch = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_idx_q != 3'd4) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        sdout_d   = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[3:1]};
                        frame_d   = 1'b1;
                    end else begin
                        done_d    = 1'b1;
                        cnt_d     = cnt_q + 4'd1;
                        gap_cnt_d = GAP_LOAD;
                        bit_idx_d = 3'd0;
                        state_d   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 3'd0) begin
                        if (full_q) begin
                            launch = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Move the buffered word into the shifter and put d0 on the line.
            if (launch) begin
                shreg_d   = buf_q[4:1];
                sdout_d   = buf_q[0];
                frame_d   = 1'b1;
                bit_idx_d = 3'd0;
                state_d   = ST_SHIFT;
                full_d    = 1'b0;
            end

            // A draining buffer can be refilled on the same edge.
            if (i_load && (!full_q || launch)) begin
                buf_d    = {i_gain[0], i_gain[1], i_gain[2], i_mode[1], i_mode[0]};
                full_d   = 1'b1;
                accept_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE) || full_d;
    end

    // State and registered outputs, cleared asynchronously by i_resetbAll.
    always_ff @(posedge i_sclk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            state_q   <= ST_IDLE;
            buf_q     <= 5'd0;
            full_q    <= 1'b0;
            shreg_q   <= 4'd0;
            bit_idx_q <= 3'd0;
            gap_cnt_q <= 3'd0;
            sdout_q   <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            accept_q  <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            full_q    <= full_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            sdout_q   <= sdout_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            accept_q  <= accept_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_accept    = accept_q;
    assign o_sdout     = sdout_q;
    assign o_frame     = frame_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_cnt = cnt_q;

endmodule
